// File: rtl/pkt_dvdr_pkg.sv
// Shared constants and enumerations for the packet-divider receive path.
package pkt_dvdr_pkg;

  localparam logic [7:0]  SOP_BYTE    = 8'hB8;
  localparam logic [7:0]  EOP_BYTE    = 8'hE7;
  localparam logic [7:0]  PAD_BYTE    = 8'h00;
  localparam int unsigned MIN_LEN_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_PAD,
    ST_PARITY,
    ST_EOP
  } rx_state_e;

  typedef enum logic [1:0] {
    ERR_PARITY   = 2'd0,
    ERR_BAD_EOP  = 2'd1,
    ERR_ZERO_LEN = 2'd2,
    ERR_RX_DROP  = 2'd3
  } err_code_e;

endpackage

// File: rtl/pkt_dvdr_sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module pkt_dvdr_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_dvdr_rx_parser.sv
// Receive-side frame parser: strips SOP/LEN/padding/parity/EOP framing,
// forwards payload bytes, flags frame completion or error, and keeps
// saturating good/error frame statistics.
module pkt_dvdr_rx_parser
  import pkt_dvdr_pkg::*;
#(
  parameter int unsigned MIN_LEN = MIN_LEN_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic [7:0]       rx_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] MIN_B = 8'(MIN_LEN);

  rx_state_e  state;
  err_code_e  err_q;
  logic [7:0] len_q;
  logic [7:0] cnt_q;
  logic [7:0] parity_q;
  logic       par_bad_q;

  logic       last_data;
  logic       last_pad;
  logic [7:0] pad_need;

  // Terminal-count decodes for the payload and padding phases.
  always_comb begin
    pad_need  = MIN_B - len_q;
    last_data = (cnt_q == (len_q - 8'd1));
    last_pad  = (cnt_q == (pad_need - 8'd1));
  end

  assign err_code = err_q;

  // Frame FSM with registered payload and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      err_q     <= ERR_PARITY;
      len_q     <= '0;
      cnt_q     <= '0;
      parity_q  <= '0;
      par_bad_q <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      if ((state != ST_IDLE) && !rx_en) begin
        pkt_err <= 1'b1;
        err_q   <= ERR_RX_DROP;
        state   <= ST_IDLE;
      end else if (rx_en) begin
        unique case (state)
          ST_IDLE: begin
            if (rx_data == SOP_BYTE) state <= ST_LEN;
          end
          ST_LEN: begin
            if (rx_data == 8'd0) begin
              pkt_err <= 1'b1;
              err_q   <= ERR_ZERO_LEN;
              state   <= ST_IDLE;
            end else begin
              len_q     <= rx_data;
              parity_q  <= rx_data;
              cnt_q     <= '0;
              par_bad_q <= 1'b0;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            out_valid <= 1'b1;
            out_data  <= rx_data;
            out_sop   <= (cnt_q == 8'd0);
            out_eop   <= last_data;
            parity_q  <= parity_q ^ rx_data;
            if (last_data) begin
              cnt_q <= '0;
              state <= (len_q < MIN_B) ? ST_PAD : ST_PARITY;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_PAD: begin
            parity_q <= parity_q ^ rx_data;
            cnt_q    <= cnt_q + 8'd1;
            if (last_pad) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bad_q <= (rx_data != parity_q);
            state     <= ST_EOP;
          end
          ST_EOP: begin
            // A bad EOP byte outranks a parity mismatch recorded earlier.
            if (rx_data != EOP_BYTE) begin
              pkt_err <= 1'b1;
              err_q   <= ERR_BAD_EOP;
            end else if (par_bad_q) begin
              pkt_err <= 1'b1;
              err_q   <= ERR_PARITY;
            end else begin
              pkt_done <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  pkt_dvdr_sat_cnt #(.WIDTH(CNT_W)) u_good_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (pkt_done),
    .count (good_cnt)
  );

  pkt_dvdr_sat_cnt #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (pkt_err),
    .count (err_cnt)
  );

endmodule
